// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, ARM condition evaluation and IT-block sequencer.
module cond_unit #(
  parameter int IT_MAX = 4,
  localparam int LW = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid,
  input  logic [3:0]        cond,
  input  logic [1:0]        flag_w,
  input  logic [3:0]        alu_flags,
  input  logic              it_start,
  input  logic [3:0]        it_firstcond,
  input  logic [LW-1:0]     it_len,
  input  logic [IT_MAX-1:0] it_pattern,
  output logic              cond_ex,
  output logic [3:0]        flags,
  output logic              it_active,
  output logic [LW-1:0]     it_remain,
  output logic              it_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [3:0] fc, slot_cond, ec;
  logic [IT_MAX-1:0] pat, pat_sh;
  logic [LW-1:0] idx, remain;
  logic legal, go, consume, wr;
  // Odd codes are the negation of the even code below them; AL/NV fall out of base=1.
  function automatic logic eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cy;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cy & ~z;
      3'd5:    b = n == v;
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction
  always_comb begin
    legal     = it_len != '0 && it_len <= LW'(IT_MAX);
    go        = valid & it_start & ~stall & ~flush & (state == IDLE) & legal;
    consume   = valid & ~stall & (state == ACTIVE);
    pat_sh    = pat >> idx;
    slot_cond = {fc[3:1], fc[0] ^ ~pat_sh[0]};
    ec        = state == ACTIVE ? slot_cond : cond;
    cond_ex   = valid & ((it_start & state == IDLE) | eval(ec, flags));
    wr        = valid & cond_ex & ~stall & ~it_start;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = stall ? state :
              flush ? IDLE :
              state == IDLE ? (go ? ACTIVE : IDLE) :
              (consume && remain == LW'(1)) ? IDLE : ACTIVE;
  always_comb begin
    it_active = state == ACTIVE;
    it_remain = remain;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= '0;
      fc     <= '0;
      pat    <= '0;
      idx    <= '0;
      remain <= '0;
      it_err <= 1'b0;
    end else if (stall) begin
      it_err <= 1'b0;
    end else begin
      it_err <= valid & it_start & ~flush & ((state == ACTIVE) | ~legal);
      if (wr & flag_w[1]) flags[3:2] <= alu_flags[3:2];
      if (wr & flag_w[0]) flags[1:0] <= alu_flags[1:0];
      if (flush) begin
        remain <= '0;
      end else if (go) begin
        fc     <= it_firstcond;
        pat    <= it_firstcond == 4'b1110 ? '1 : it_pattern | IT_MAX'(1);
        remain <= it_len;
        idx    <= '0;
      end else if (consume) begin
        remain <= remain - LW'(1);
        idx    <= idx + LW'(1);
      end
    end
  end
endmodule
